// File: rtl/scan_counter_2d.sv
// scan_counter_2d: rectangle scanner emitting one (x,y) per handshake
// in raster, serpentine, column-major and column-serpentine order.
module scan_counter_2d #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int X_BITS = $clog2(WIDTH),
  parameter int Y_BITS = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [X_BITS-1:0] x_start,
  input  logic [Y_BITS-1:0] y_start,
  input  logic [X_BITS-1:0] x_end,
  input  logic [Y_BITS-1:0] y_end,
  output logic [X_BITS-1:0] out_x,
  output logic [Y_BITS-1:0] out_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              first,
  output logic              line_last,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic [X_BITS-1:0] xs_q;
  logic [X_BITS-1:0] xe_q;
  logic [Y_BITS-1:0] ys_q;
  logic [Y_BITS-1:0] ye_q;
  logic              rev;
  logic              first_q;

  logic col;
  logic serp;
  logic x_lend;
  logic y_lend;
  logic lend;
  logic fin;
  logic xfer;

  // rev only reverses the inner axis; the outer axis always ascends,
  // so x_lend/y_lend double as "outer at end" for the outer axis.
  always_comb begin
    col    = mode_q[1];
    serp   = mode_q[0];
    x_lend = (rev && !col) ? (out_x == xs_q) : (out_x == xe_q);
    y_lend = (rev && col) ? (out_y == ys_q) : (out_y == ye_q);
    lend   = col ? y_lend : x_lend;
    fin    = x_lend && y_lend;
  end

  assign xfer      = out_valid && out_ready;
  assign first     = out_valid && first_q;
  assign line_last = out_valid && lend;
  assign last      = out_valid && fin;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= '0;
      xs_q      <= '0;
      xe_q      <= '0;
      ys_q      <= '0;
      ye_q      <= '0;
      rev       <= 1'b0;
      first_q   <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            xs_q   <= x_start;
            xe_q   <= x_end;
            ys_q   <= y_start;
            ye_q   <= y_end;
            rev    <= 1'b0;
            if (x_end < x_start || y_end < y_start) begin
              err <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              first_q   <= 1'b1;
              out_x     <= x_start;
              out_y     <= y_start;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            first_q   <= 1'b0;
          end else if (xfer) begin
            first_q <= 1'b0;
            if (fin) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else if (lend) begin
              if (serp) rev <= ~rev;
              if (col) begin
                out_x <= out_x + 1'b1;
                if (!serp) out_y <= ys_q;
              end else begin
                out_y <= out_y + 1'b1;
                if (!serp) out_x <= xs_q;
              end
            end else if (col) begin
              out_y <= rev ? out_y - 1'b1 : out_y + 1'b1;
            end else begin
              out_x <= rev ? out_x - 1'b1 : out_x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scan_counter_2d.md
Name: scan_counter_2d

Overview:
- Parameterised 2-D rectangle scanner; successor to the basic x/y counter.
- Emits one (x, y) coordinate per valid/ready handshake over a rectangle [x_start..x_end] × [y_start..y_end].
- Four traversal modes: raster, serpentine, column-major, column-serpentine.
- Start/busy/done control handshake, abort, per-point position flags. Drives pixel fill/blit engines and framebuffer readers.

Parameters:
- WIDTH, 640, number of X positions addressable.
- HEIGHT, 480, number of Y positions addressable.
- X_BITS, $clog2(WIDTH), coordinate width for x.
- Y_BITS, $clog2(HEIGHT), coordinate width for y.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  begin a scan; honoured only when idle.
- abort  in  1  terminate the current scan immediately.
- mode  in  2  0 raster, 1 serpentine, 2 column-major, 3 column-serpentine.
- x_start  in  X_BITS  first column.
- y_start  in  Y_BITS  first row.
- x_end  in  X_BITS  last column, inclusive.
- y_end  in  Y_BITS  last row, inclusive.
- out_x  out  X_BITS  current x.
- out_y  out  Y_BITS  current y.
- out_valid  out  1  out_x/out_y hold a point.
- out_ready  in  1  consumer accepts the point.
- first  out  1  current point is the first of the scan.
- line_last  out  1  current point ends its inner line (row, or column in modes 2/3).
- last  out  1  current point is the final point of the scan.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse at normal completion.
- err  out  1  one-cycle pulse when start is rejected for a bad rectangle.

Behaviour:
- Synchronous, active-low reset. While rst_n=0 at a clock edge:
  - out_x, out_y, out_valid, first, line_last, last, busy, done, err all reset to 0.
  - FSM goes to IDLE.
  - Reset mid-scan discards the scan with no done pulse.
- FSM states: IDLE, RUN.
- IDLE, start=1:
  - Latch mode and all four bounds into internal registers; later input changes are ignored until the next start.
  - If x_end<x_start or y_end<y_start: stay IDLE, pulse err next cycle, emit no points.
  - Otherwise next cycle: RUN, busy=1, out_valid=1, first=1, point=(x_start, y_start).
- Start latency: exactly 1 cycle from start to the first out_valid.
- Handshake:
  - A point transfers when out_valid&&out_ready.
  - Without a transfer, out_x, out_y and all flags hold stable.
  - After a non-final transfer, the next point appears the following cycle with out_valid kept at 1 (zero-bubble, one point per cycle at full throughput).
- Traversal, raster (0):
  - x increments to x_end, then wraps to x_start and y increments.
  - Inner line is the row.
- Traversal, serpentine (1):
  - Row index k = y − y_start.
  - Even k: x_start→x_end. Odd k: x_end→x_start.
  - At a row change x holds its end value and y increments.
- Column modes (2, 3): same as modes 0 and 1 with the roles of x and y swapped.
- Comparisons are on latched bounds. x and y never leave [start..end], so there is no arithmetic overflow even when x_end = 2^X_BITS−1.
- Flags, all combinational on the current point:
  - line_last: the inner coordinate is at the end of its current direction.
  - last: line_last and the outer coordinate equals its end.
  - first: the current point is the scan's first point.
- Completion:
  - Transfer of the last point moves to IDLE; out_valid=0 and busy=0 next cycle; done=1 for that cycle only.
  - Point count is (x_end−x_start+1)·(y_end−y_start+1).
  - A degenerate 1×1 rectangle yields one point with first=line_last=last=1.
- abort=1 in RUN: next cycle IDLE, out_valid=0, busy=0, no done. Abort takes priority over a same-cycle transfer.
- start while RUN is ignored. start and abort together in IDLE: start is honoured.
- done and a new start in the same cycle: the new scan is accepted.

Test Plan:
- Raster, mode=0, x 2..4, y 1..2, ready always 1 → sequence (2,1)(3,1)(4,1)(2,2)(3,2)(4,2); line_last on (4,1) and (4,2); last on (4,2); done 1 cycle after; first point 1 cycle after start.
- Serpentine, mode=1, x 0..2, y 0..2 → (0,0)(1,0)(2,0)(2,1)(1,1)(0,1)(0,2)(1,2)(2,2); 9 points; last=1 only on (2,2).
- Column-serpentine, mode=3, x 0..1, y 0..2 → (0,0)(0,1)(0,2)(1,2)(1,1)(1,0); line_last on (0,2) and (1,0).
- Backpressure: raster 4×1, out_ready toggling 1,0,0,1,... → out_x/out_y/flags stable while ready=0; exactly 4 transfers; done after the 4th.
- Errors and edges:
  - x_start=5, x_end=3 → err pulse, busy stays 0, no out_valid.
  - 1×1 at (WIDTH−1, HEIGHT−1) → single point with all flags set; no wrap to 0.
- Abort/reset mid-scan:
  - Abort asserted on the 3rd point of 3×3 → out_valid=0 next cycle, no done; a new start then begins at (x_start, y_start) with first=1.
  - rst_n=0 mid-scan → all outputs 0 next cycle.
